// File: rtl/matrix_cmd_seq_if.sv
// matrix_cmd_seq_if: command stream, stack and multiplier bus of the sequencer.
// err_tmo exists only when MATRIX_SEQ_TIMEOUT_EN is defined.
interface matrix_cmd_seq_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [127:0] cmd_data;
  logic [127:0] peek_in_0;
  logic [127:0] peek_in_1;
  logic [127:0] peek_in_2;
  logic [127:0] peek_in_3;
  logic         matrix_mode;
  logic         load_en;
  logic         load_id_en;
  logic         pop_en;
  logic         write_en;
  logic [127:0] data_out;
  logic         mul_start;
  logic         mul_done;
  logic [127:0] mul_op_0;
  logic [127:0] mul_op_1;
  logic [127:0] mul_op_2;
  logic [127:0] mul_op_3;
  logic         busy;
  logic         err_ovf;
  logic         err_unf;
  logic         err_clr;
`ifdef MATRIX_SEQ_TIMEOUT_EN
  logic         err_tmo;
`endif

  modport slave (
`ifdef MATRIX_SEQ_TIMEOUT_EN
    output err_tmo,
`endif
    input  cmd_valid, cmd_op, cmd_data,
    input  peek_in_0, peek_in_1, peek_in_2, peek_in_3,
    input  mul_done, err_clr,
    output cmd_ready, matrix_mode,
    output load_en, load_id_en, pop_en, write_en,
    output data_out, mul_start,
    output mul_op_0, mul_op_1, mul_op_2, mul_op_3,
    output busy, err_ovf, err_unf
  );

  modport master (
`ifdef MATRIX_SEQ_TIMEOUT_EN
    input  err_tmo,
`endif
    output cmd_valid, cmd_op, cmd_data,
    output peek_in_0, peek_in_1, peek_in_2, peek_in_3,
    output mul_done, err_clr,
    input  cmd_ready, matrix_mode,
    input  load_en, load_id_en, pop_en, write_en,
    input  data_out, mul_start,
    input  mul_op_0, mul_op_1, mul_op_2, mul_op_3,
    input  busy, err_ovf, err_unf
  );
endinterface

// File: rtl/matrix_cmd_seq.sv
// matrix_cmd_seq: GL matrix command sequencer in front of the matrix stack.
// Optional: define MATRIX_SEQ_TIMEOUT_EN for a multiplier watchdog (err_tmo).
module matrix_cmd_seq #(
  parameter int MV_DEPTH    = 32,
  parameter int PJ_DEPTH    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input logic             clk,
  input logic             rst,
  matrix_cmd_seq_if.slave bus
);
  localparam int DMAX = (MV_DEPTH > PJ_DEPTH) ? MV_DEPTH : PJ_DEPTH;
  localparam int DW   = $clog2(DMAX + 1);

  localparam logic [2:0] OP_MODE = 3'd1;
  localparam logic [2:0] OP_LDID = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_PUSH = 3'd4;
  localparam logic [2:0] OP_POP  = 3'd5;
  localparam logic [2:0] OP_MULT = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_COLLECT,
    S_BURST0, S_BURST1, S_BURST2, S_BURST3,
    S_MUL_COLLECT, S_MUL_WAIT, S_MUL_WB
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic            r_mode;
  logic [DW-1:0]   r_mv_depth;
  logic [DW-1:0]   r_pj_depth;
  logic [1:0]      r_cnt;
  logic [127:0]    r_shadow [4];
  logic [127:0]    r_mul_op [4];
  logic            r_load_id_en;
  logic            r_pop_en;
  logic            r_mul_start;
  logic            r_err_ovf;
  logic            r_err_unf;
  logic            w_ready;
  logic            w_acc;
  logic            w_last;
  logic            w_full;
  logic            w_empty;
  logic            w_idle_op;
  logic            w_dec;
  logic            w_load_en;
  logic            w_write_en;
  logic            w_set_ovf;
  logic            w_set_unf;
  logic            w_tmo;
  logic [127:0]    w_dout;

  assign w_ready = !rst && (r_state == S_IDLE ||
                            r_state == S_COLLECT ||
                            r_state == S_MUL_COLLECT);
  assign w_acc     = bus.cmd_valid && w_ready;
  assign w_idle_op = w_acc && (r_state == S_IDLE);
  assign w_last    = (r_cnt == 2'd2);
  assign w_full    = r_mode ? (r_pj_depth == DW'(PJ_DEPTH))
                            : (r_mv_depth == DW'(MV_DEPTH));
  assign w_empty   = r_mode ? (r_pj_depth == DW'(1))
                            : (r_mv_depth == DW'(1));
  assign w_dec     = w_idle_op && (bus.cmd_op == OP_POP) && !w_empty;

`ifdef MATRIX_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_err_tmo;

  assign w_tmo = (r_state == S_MUL_WAIT) && !bus.mul_done &&
                 (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Watchdog: count cycles spent waiting on the multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_err_tmo <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == S_MUL_WAIT) ? r_tmo_cnt + 1'b1 : '0;
      if (w_tmo)            r_err_tmo <= 1'b1;
      else if (bus.err_clr) r_err_tmo <= 1'b0;
    end
  end

  assign bus.err_tmo = r_err_tmo;
`else
  assign w_tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // Next state, burst strobes and error set conditions
  always_comb begin
    w_nxt      = r_state;
    w_load_en  = 1'b0;
    w_write_en = 1'b0;
    w_dout     = '0;
    w_set_ovf  = 1'b0;
    w_set_unf  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          unique case (bus.cmd_op)
            OP_LOAD: w_nxt = S_COLLECT;
            OP_PUSH: begin
              if (w_full) w_set_ovf = 1'b1;
              else        w_nxt     = S_BURST0;
            end
            OP_POP:  w_set_unf = w_empty;
            OP_MULT: w_nxt = S_MUL_COLLECT;
            default: ;
          endcase
        end
      end
      S_COLLECT: begin
        if (w_acc && w_last) begin
          if (w_full) begin
            w_set_ovf = 1'b1;
            w_nxt     = S_IDLE;
          end else begin
            w_nxt = S_BURST0;
          end
        end
      end
      S_BURST0: begin
        w_load_en = 1'b1;
        w_dout    = r_shadow[0];
        w_nxt     = S_BURST1;
      end
      S_BURST1: begin
        w_dout = r_shadow[1];
        w_nxt  = S_BURST2;
      end
      S_BURST2: begin
        w_dout = r_shadow[2];
        w_nxt  = S_BURST3;
      end
      S_BURST3: begin
        w_dout = r_shadow[3];
        w_nxt  = S_IDLE;
      end
      S_MUL_COLLECT: begin
        if (w_acc && w_last) w_nxt = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (bus.mul_done) w_nxt = S_MUL_WB;
        else if (w_tmo)   w_nxt = S_IDLE;
      end
      S_MUL_WB: begin
        w_write_en = 1'b1;
        w_nxt      = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Row capture, mode register and one-cycle-late strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode       <= 1'b0;
      r_cnt        <= 2'd0;
      r_load_id_en <= 1'b0;
      r_pop_en     <= 1'b0;
      r_mul_start  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= '0;
        r_mul_op[i] <= '0;
      end
    end else begin
      r_load_id_en <= 1'b0;
      r_pop_en     <= 1'b0;
      r_mul_start  <= 1'b0;
      if (w_idle_op) begin
        r_cnt <= 2'd0;
        unique case (bus.cmd_op)
          OP_MODE: r_mode <= bus.cmd_data[0];
          OP_LDID: r_load_id_en <= 1'b1;
          OP_LOAD: r_shadow[0] <= bus.cmd_data;
          OP_PUSH: begin
            if (!w_full) begin
              r_shadow[0] <= bus.peek_in_0;
              r_shadow[1] <= bus.peek_in_1;
              r_shadow[2] <= bus.peek_in_2;
              r_shadow[3] <= bus.peek_in_3;
            end
          end
          OP_POP:  r_pop_en <= !w_empty;
          OP_MULT: r_mul_op[0] <= bus.cmd_data;
          default: ;
        endcase
      end else if (w_acc && r_state == S_COLLECT) begin
        r_shadow[r_cnt + 2'd1] <= bus.cmd_data;
        r_cnt                  <= r_cnt + 2'd1;
      end else if (w_acc) begin
        r_mul_op[r_cnt + 2'd1] <= bus.cmd_data;
        r_cnt                  <= r_cnt + 2'd1;
        r_mul_start            <= w_last;
      end
    end
  end

  // Per-mode stack depth: +1 at burst end, -1 on an accepted pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mv_depth <= DW'(1);
      r_pj_depth <= DW'(1);
    end else if (r_state == S_BURST3) begin
      if (r_mode) r_pj_depth <= r_pj_depth + 1'b1;
      else        r_mv_depth <= r_mv_depth + 1'b1;
    end else if (w_dec) begin
      if (r_mode) r_pj_depth <= r_pj_depth - 1'b1;
      else        r_mv_depth <= r_mv_depth - 1'b1;
    end
  end

  // Sticky errors; a same-cycle set beats err_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (w_set_ovf)        r_err_ovf <= 1'b1;
      else if (bus.err_clr) r_err_ovf <= 1'b0;
      if (w_set_unf)        r_err_unf <= 1'b1;
      else if (bus.err_clr) r_err_unf <= 1'b0;
    end
  end

  assign bus.cmd_ready   = w_ready;
  assign bus.matrix_mode = r_mode;
  assign bus.load_en     = w_load_en;
  assign bus.load_id_en  = r_load_id_en;
  assign bus.pop_en      = r_pop_en;
  assign bus.write_en    = w_write_en;
  assign bus.data_out    = w_dout;
  assign bus.mul_start   = r_mul_start;
  assign bus.mul_op_0    = r_mul_op[0];
  assign bus.mul_op_1    = r_mul_op[1];
  assign bus.mul_op_2    = r_mul_op[2];
  assign bus.mul_op_3    = r_mul_op[3];
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.err_ovf     = r_err_ovf;
  assign bus.err_unf     = r_err_unf;
endmodule

// File: tb/tb_matrix_cmd_seq.sv
// tb_matrix_cmd_seq: directed cycle vectors plus burst/overflow/reset sequences.
// Outputs are sampled on the falling edge; inputs change 1ns after rising.
module tb_matrix_cmd_seq;
  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] MODE = 3'd1;
  localparam logic [2:0] LDID = 3'd2;
  localparam logic [2:0] LOAD = 3'd3;
  localparam logic [2:0] PUSH = 3'd4;
  localparam logic [2:0] POP  = 3'd5;
  localparam logic [2:0] MULT = 3'd6;

  localparam logic [127:0] Z  = '0;
  localparam logic [127:0] RA = {4{32'hA1A1_0001}};
  localparam logic [127:0] RB = {4{32'hB2B2_0002}};
  localparam logic [127:0] RC = {4{32'hC3C3_0003}};
  localparam logic [127:0] RD = {4{32'hD4D4_0004}};
  localparam logic [127:0] P0 = {4{32'h5050_0010}};
  localparam logic [127:0] P1 = {4{32'h5151_0011}};
  localparam logic [127:0] P2 = {4{32'h5252_0012}};
  localparam logic [127:0] P3 = {4{32'h5353_0013}};
  localparam logic [127:0] M0 = {4{32'hE0E0_0020}};
  localparam logic [127:0] M1 = {4{32'hE1E1_0021}};
  localparam logic [127:0] M2 = {4{32'hE2E2_0022}};
  localparam logic [127:0] M3 = {4{32'hE3E3_0023}};

  typedef struct packed {
    logic rdy, mode, ld, lid, pop, wr, ms, busy, ovf, unf;
    logic [127:0] d;
  } outs_t;

  typedef struct {
    bit         v;
    logic [2:0] op;
    logic [127:0] d;
    bit         dn;
    bit         cl;
    outs_t      e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  matrix_cmd_seq_if bus();

  matrix_cmd_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic outs_t o(bit rdy, bit mode, bit ld, bit lid, bit pop,
                              bit wr, bit ms, bit busy, bit ovf, bit unf,
                              logic [127:0] d);
    outs_t r;
    r.rdy = rdy; r.mode = mode; r.ld = ld; r.lid = lid; r.pop = pop;
    r.wr = wr; r.ms = ms; r.busy = busy; r.ovf = ovf; r.unf = unf;
    r.d = d;
    return r;
  endfunction

  function automatic vec_t mk(bit v, logic [2:0] op, logic [127:0] d,
                              bit dn, bit cl, outs_t e);
    vec_t r;
    r.v = v; r.op = op; r.d = d; r.dn = dn; r.cl = cl; r.e = e;
    return r;
  endfunction

  function automatic outs_t cur();
    outs_t r;
    r.rdy  = bus.cmd_ready;  r.mode = bus.matrix_mode;
    r.ld   = bus.load_en;    r.lid  = bus.load_id_en;
    r.pop  = bus.pop_en;     r.wr   = bus.write_en;
    r.ms   = bus.mul_start;  r.busy = bus.busy;
    r.ovf  = bus.err_ovf;    r.unf  = bus.err_unf;
    r.d    = bus.data_out;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [137:0] act,
                     input logic [137:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] op,
                       input logic [127:0] d, input bit dn, input bit cl);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.mul_done  = dn;
    bus.err_clr   = cl;
  endtask

  task automatic step(input bit v, input logic [2:0] op,
                      input logic [127:0] d, input bit dn, input bit cl,
                      input string nm, input outs_t e);
    @(posedge clk);
    #1;
    drive(v, op, d, dn, cl);
    @(negedge clk);
    chk(nm, cur(), e);
  endtask

  initial begin
    drive(1'b0, NOP, Z, 1'b0, 1'b0);
    bus.peek_in_0 = P0;
    bus.peek_in_1 = P1;
    bus.peek_in_2 = P2;
    bus.peek_in_3 = P3;

    // rdy mode ld lid pop wr ms busy ovf unf data
    tv.push_back(mk(1, MODE, 128'd1, 0, 0, o(1,0,0,0,0,0,0,0,0,0,Z)));
    tv.push_back(mk(1, LOAD, RA, 0, 0, o(1,1,0,0,0,0,0,0,0,0,Z)));
    tv.push_back(mk(1, NOP,  RB, 0, 0, o(1,1,0,0,0,0,0,1,0,0,Z)));
    tv.push_back(mk(1, NOP,  RC, 0, 0, o(1,1,0,0,0,0,0,1,0,0,Z)));
    tv.push_back(mk(1, NOP,  RD, 0, 0, o(1,1,0,0,0,0,0,1,0,0,Z)));
    tv.push_back(mk(1, NOP,  Z,  0, 0, o(0,1,1,0,0,0,0,1,0,0,RA)));
    tv.push_back(mk(1, NOP,  Z,  0, 0, o(0,1,0,0,0,0,0,1,0,0,RB)));
    tv.push_back(mk(1, NOP,  Z,  0, 0, o(0,1,0,0,0,0,0,1,0,0,RC)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(0,1,0,0,0,0,0,1,0,0,RD)));
    tv.push_back(mk(1, PUSH, Z,  0, 0, o(1,1,0,0,0,0,0,0,0,0,Z)));
    tv.push_back(mk(0, NOP,  Z,  0, 1, o(1,1,0,0,0,0,0,0,1,0,Z)));
    tv.push_back(mk(1, POP,  Z,  0, 0, o(1,1,0,0,0,0,0,0,0,0,Z)));
    tv.push_back(mk(1, POP,  Z,  0, 0, o(1,1,0,0,1,0,0,0,0,0,Z)));
    tv.push_back(mk(1, MODE, Z,  0, 0, o(1,1,0,0,0,0,0,0,0,1,Z)));
    tv.push_back(mk(1, POP,  Z,  0, 1, o(1,0,0,0,0,0,0,0,0,1,Z)));
    tv.push_back(mk(0, NOP,  Z,  0, 1, o(1,0,0,0,0,0,0,0,0,1,Z)));
    tv.push_back(mk(1, LDID, Z,  0, 0, o(1,0,0,0,0,0,0,0,0,0,Z)));
    tv.push_back(mk(1, PUSH, Z,  0, 0, o(1,0,0,1,0,0,0,0,0,0,Z)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(0,0,1,0,0,0,0,1,0,0,P0)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(0,0,0,0,0,0,0,1,0,0,P1)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(0,0,0,0,0,0,0,1,0,0,P2)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(0,0,0,0,0,0,0,1,0,0,P3)));
    tv.push_back(mk(1, POP,  Z,  0, 0, o(1,0,0,0,0,0,0,0,0,0,Z)));
    tv.push_back(mk(1, MULT, M0, 0, 0, o(1,0,0,0,1,0,0,0,0,0,Z)));
    tv.push_back(mk(1, NOP,  M1, 0, 0, o(1,0,0,0,0,0,0,1,0,0,Z)));
    tv.push_back(mk(1, NOP,  M2, 0, 0, o(1,0,0,0,0,0,0,1,0,0,Z)));
    tv.push_back(mk(1, NOP,  M3, 0, 0, o(1,0,0,0,0,0,0,1,0,0,Z)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(0,0,0,0,0,0,1,1,0,0,Z)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(0,0,0,0,0,0,0,1,0,0,Z)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(0,0,0,0,0,0,0,1,0,0,Z)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(0,0,0,0,0,0,0,1,0,0,Z)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(0,0,0,0,0,0,0,1,0,0,Z)));
    tv.push_back(mk(0, NOP,  Z,  1, 0, o(0,0,0,0,0,0,0,1,0,0,Z)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(0,0,0,0,0,1,0,1,0,0,Z)));
    tv.push_back(mk(0, NOP,  Z,  0, 0, o(1,0,0,0,0,0,0,0,0,0,Z)));

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", cur(), o(0,0,0,0,0,0,0,0,0,0,Z));
    chk("reset_mulop0", {10'b0, bus.mul_op_0}, {10'b0, Z});
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tv.size(); i++)
      step(tv[i].v, tv[i].op, tv[i].d, tv[i].dn, tv[i].cl,
           $sformatf("vec%0d", i), tv[i].e);

    chk("mul_op_0", {10'b0, bus.mul_op_0}, {10'b0, M0});
    chk("mul_op_1", {10'b0, bus.mul_op_1}, {10'b0, M1});
    chk("mul_op_2", {10'b0, bus.mul_op_2}, {10'b0, M2});
    chk("mul_op_3", {10'b0, bus.mul_op_3}, {10'b0, M3});

    // Projection: push fits once, second push overflows
    step(1, MODE, 128'd1, 0, 0, "pj_mode", o(1,0,0,0,0,0,0,0,0,0,Z));
    step(1, PUSH, Z, 0, 0, "pj_push1", o(1,1,0,0,0,0,0,0,0,0,Z));
    step(0, NOP, Z, 0, 0, "pj_b0", o(0,1,1,0,0,0,0,1,0,0,P0));
    step(0, NOP, Z, 0, 0, "pj_b1", o(0,1,0,0,0,0,0,1,0,0,P1));
    step(0, NOP, Z, 0, 0, "pj_b2", o(0,1,0,0,0,0,0,1,0,0,P2));
    step(0, NOP, Z, 0, 0, "pj_b3", o(0,1,0,0,0,0,0,1,0,0,P3));
    step(1, PUSH, Z, 0, 0, "pj_push2", o(1,1,0,0,0,0,0,0,0,0,Z));
    step(0, NOP, Z, 0, 1, "pj_ovf", o(1,1,0,0,0,0,0,0,1,0,Z));
    step(0, NOP, Z, 0, 0, "pj_clr", o(1,1,0,0,0,0,0,0,0,0,Z));

    // Overflowing LOAD still swallows all four rows
    step(1, LOAD, RA, 0, 0, "lovf_r0", o(1,1,0,0,0,0,0,0,0,0,Z));
    step(1, NOP, RB, 0, 0, "lovf_r1", o(1,1,0,0,0,0,0,1,0,0,Z));
    step(1, NOP, RC, 0, 0, "lovf_r2", o(1,1,0,0,0,0,0,1,0,0,Z));
    step(1, NOP, RD, 0, 0, "lovf_r3", o(1,1,0,0,0,0,0,1,0,0,Z));
    step(1, MODE, Z, 0, 0, "lovf_idle", o(1,1,0,0,0,0,0,0,1,0,Z));
    step(0, NOP, Z, 0, 1, "lovf_mode", o(1,0,0,0,0,0,0,0,1,0,Z));
    step(0, NOP, Z, 0, 0, "lovf_clr", o(1,0,0,0,0,0,0,0,0,0,Z));

    // Reset in BURST2 aborts, next LOAD is normal
    step(1, LOAD, RA, 0, 0, "rs_r0", o(1,0,0,0,0,0,0,0,0,0,Z));
    step(1, NOP, RB, 0, 0, "rs_r1", o(1,0,0,0,0,0,0,1,0,0,Z));
    step(1, NOP, RC, 0, 0, "rs_r2", o(1,0,0,0,0,0,0,1,0,0,Z));
    step(1, NOP, RD, 0, 0, "rs_r3", o(1,0,0,0,0,0,0,1,0,0,Z));
    step(0, NOP, Z, 0, 0, "rs_b0", o(0,0,1,0,0,0,0,1,0,0,RA));
    step(0, NOP, Z, 0, 0, "rs_b1", o(0,0,0,0,0,0,0,1,0,0,RB));
    step(0, NOP, Z, 0, 0, "rs_b2", o(0,0,0,0,0,0,0,1,0,0,RC));
    #1 rst = 1'b1;
    #1 chk("rs_abort", cur(), o(0,0,0,0,0,0,0,0,0,0,Z));
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, LOAD, RA, 0, 0, "rs2_r0", o(1,0,0,0,0,0,0,0,0,0,Z));
    step(1, NOP, RB, 0, 0, "rs2_r1", o(1,0,0,0,0,0,0,1,0,0,Z));
    step(1, NOP, RC, 0, 0, "rs2_r2", o(1,0,0,0,0,0,0,1,0,0,Z));
    step(1, NOP, RD, 0, 0, "rs2_r3", o(1,0,0,0,0,0,0,1,0,0,Z));
    step(0, NOP, Z, 0, 0, "rs2_b0", o(0,0,1,0,0,0,0,1,0,0,RA));
    step(0, NOP, Z, 0, 0, "rs2_b1", o(0,0,0,0,0,0,0,1,0,0,RB));
    step(0, NOP, Z, 0, 0, "rs2_b2", o(0,0,0,0,0,0,0,1,0,0,RC));
    step(0, NOP, Z, 0, 0, "rs2_b3", o(0,0,0,0,0,0,0,1,0,0,RD));
    step(0, NOP, Z, 0, 0, "rs2_idle", o(1,0,0,0,0,0,0,0,0,0,Z));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/matrix_cmd_seq.md
Name: matrix_cmd_seq

Overview:
- Command sequencer between the GL command decoder and the matrix stack controller.
- Accepts glMatrixMode, glLoadIdentity, glLoadMatrix, glPushMatrix, glPopMatrix and glMultMatrix commands over a valid/ready stream.
- Generates the stack's single-cycle strobes and its 4-consecutive-cycle row bursts, and runs the external 4x4 multiplier handshake.
- Tracks stack depth per mode and drops overflow/underflow commands.

Parameters:
- MV_DEPTH, 32, modelview stack capacity in matrices.
- PJ_DEPTH, 2, projection stack capacity in matrices.
- TIMEOUT_CYC, 255, multiplier watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command/row beat valid
- cmd_ready  out  1  beat accepted when valid&ready
- cmd_op  in  3  0 NOP, 1 MODE, 2 LOAD_ID, 3 LOAD, 4 PUSH, 5 POP, 6 MULT, 7 reserved (treated as NOP); sampled on the first beat only
- cmd_data  in  128  row data; MODE uses bit 0
- peek_in_0..3  in  128 each  top-of-stack rows from the stack
- matrix_mode  out  1  0 modelview, 1 projection
- load_en, load_id_en, pop_en, write_en  out  1 each  stack strobes, one-cycle pulses
- data_out  out  128  row to the stack's data_in
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_done  in  1  multiplier result valid; result is routed to the stack's write_in ports externally
- mul_op_0..3  out  128 each  latched operand rows
- busy  out  1  high whenever state != IDLE
- err_ovf, err_unf  out  1 each  sticky error flags
- err_clr  in  1  clears both error flags

Behaviour:
- Reset values: all outputs 0; matrix_mode=0; mv_depth=1, pj_depth=1; state IDLE. The stack's initial pointer holds one matrix per mode.
- States: IDLE, COLLECT (3 more rows), BURST0..BURST3, MUL_COLLECT, MUL_WAIT, MUL_WB.
- cmd_ready=1 in IDLE, COLLECT and MUL_COLLECT; 0 otherwise.
- At most one stack strobe is high in any cycle.
- MODE: matrix_mode<=cmd_data[0] on the accept edge; stay in IDLE.
- LOAD_ID: load_id_en pulses on the cycle after acceptance.
- NOP/reserved: consumed, no effect.
- LOAD: the accepted beat is row0 into shadow[0]. COLLECT accepts 3 more beats into shadow[1..3].
- Burst (LOAD and PUSH): BURST0 drives load_en=1 with data_out=shadow[0]. BURST1..3 drive shadow[1..3] on consecutive cycles with no stall allowed. Then return to IDLE; depth of the current mode +1.
- PUSH: on accept, peek_in_0..3 are latched into shadow[0..3], then go straight to BURST0. Push is a copy-of-top via the load path.
- POP: pop_en pulses on the cycle after acceptance; depth -1.
- MULT: the accepted beat plus 3 more beats are latched into mul_op_0..3. Pulse mul_start, go to MUL_WAIT. On mul_done go to MUL_WB, pulse write_en for one cycle, return to IDLE. Depth unchanged.
- Overflow: LOAD or PUSH with depth==capacity for the current mode. For LOAD, the rows are still collected (stream stays aligned), then the burst is skipped and err_ovf<=1. For PUSH, the burst is skipped and err_ovf<=1.
- Underflow: POP with depth==1 → pop_en not asserted, err_unf<=1.
- err_clr has lower priority than a same-cycle error set.
- MODE changes take effect only in IDLE; matrix_mode is stable throughout any burst or multiply.
- Reset mid-operation aborts immediately to IDLE with no further strobes; depth counters return to 1.

Optional Feature:
- MATRIX_SEQ_TIMEOUT_EN: a counter in MUL_WAIT; if mul_done is absent for TIMEOUT_CYC cycles, return to IDLE without write_en and set sticky output err_tmo (port present only when defined).
- Without the macro: MUL_WAIT waits indefinitely and there is no err_tmo port.

Test Plan:
- MODE(1), then LOAD rows A,B,C,D on consecutive beats → load_en with data_out=A, then B,C,D on the next 3 cycles; matrix_mode=1 throughout; pj_depth=2.
- PUSH with peek_in_0..3=P0..P3 → load_en with data_out=P0, then P1,P2,P3 on consecutive cycles; cmd_ready=0 for 4 cycles.
- In projection mode: PUSH, then PUSH again → second push produces no load_en and err_ovf=1; err_clr drops it next cycle.
- POP with depth 1 → no pop_en, err_unf=1; after one PUSH, POP → pop_en pulses once.
- MULT rows M0..M3, mul_done asserted 5 cycles after mul_start → mul_op_0..3=M0..M3 and exactly one write_en the cycle after mul_done.
- rst asserted during BURST2 → all strobes 0 immediately, busy=0, next LOAD behaves normally.
